// File: rtl/tri_feed_arbiter_pkg.sv
// Shared definitions for the triangle feed arbiter: one-hot FSM encoding,
// vertex bundle geometry and a coordinate extraction helper.
package tri_feed_arbiter_pkg;

    localparam int COORD_W    = 3;
    localparam int NUM_COORDS = 6;
    localparam int BUNDLE_W   = COORD_W * NUM_COORDS;
    localparam int CNT_W      = 8;

    localparam logic [COORD_W-1:0] ZERO_PT = 3'd0;

    // Indices of the six coordinates inside a bundle, x1 sits in the top bits.
    localparam int unsigned IDX_X1 = 32'd0;
    localparam int unsigned IDX_Y1 = 32'd1;
    localparam int unsigned IDX_X2 = 32'd2;
    localparam int unsigned IDX_Y2 = 32'd3;
    localparam int unsigned IDX_X3 = 32'd4;
    localparam int unsigned IDX_Y3 = 32'd5;

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        V1      = 6'b000010,
        V2      = 6'b000100,
        V3      = 6'b001000,
        WAIT_HI = 6'b010000,
        WAIT_LO = 6'b100000
    } state_e;

    // Pull coordinate number idx (0 = x1 ... 5 = y3) out of a vertex bundle.
    function automatic logic [COORD_W-1:0] get_coord(input logic [BUNDLE_W-1:0] bundle,
                                                     input int unsigned       idx);
        logic [BUNDLE_W-1:0] shifted;
        shifted = bundle >> (COORD_W * (NUM_COORDS - 1 - idx));
        return shifted[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/tri_feed_arbiter_if.sv
// Handshake and vertex bus between the two triangle requesters, the
// arbiter and the rasterizer. Signal suffixes are from the arbiter's view.
interface tri_feed_arbiter_if;
    import tri_feed_arbiter_pkg::*;

    logic                      req0_i;
    logic                      req1_i;
    logic [BUNDLE_W-1:0]       tri0_i;
    logic [BUNDLE_W-1:0]       tri1_i;
    logic                      busy_i;
    logic                      gnt0_o;
    logic                      gnt1_o;
    logic                      done0_o;
    logic                      done1_o;
    logic                      nt_o;
    logic [COORD_W-1:0]        xo_o;
    logic [COORD_W-1:0]        yo_o;
    logic [CNT_W-1:0]          tri_cnt_o;

    // Arbiter side.
    modport slave (
        input  req0_i, req1_i, tri0_i, tri1_i, busy_i,
        output gnt0_o, gnt1_o, done0_o, done1_o, nt_o, xo_o, yo_o, tri_cnt_o
    );

    // Requester / rasterizer side.
    modport master (
        output req0_i, req1_i, tri0_i, tri1_i, busy_i,
        input  gnt0_o, gnt1_o, done0_o, done1_o, nt_o, xo_o, yo_o, tri_cnt_o
    );
endinterface

// File: rtl/tri_feed_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, on a tie the
// requester that was not served last wins. Winner is one-hot {w1,w0}.
module rr_arb2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] win_o
);

    // Select the winner from the request pair and the last-served pointer.
    always_comb begin
        win_o = 2'b00;
        if (req0_i && req1_i) begin
            win_o = last_i ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            win_o = 2'b01;
        end else if (req1_i) begin
            win_o = 2'b10;
        end else begin
            win_o = 2'b00;
        end
    end

endmodule

// File: rtl/tri_feed_arbiter.sv
// Feeds triangles from two requesters to a single rasterizer. A winner's
// vertex bundle is latched, streamed as three vertices, then the arbiter
// waits for the rasterizer's busy high/low handshake before reporting done.
// All outputs decode from registers only, so reset clears them at once.
module tri_feed_arbiter
    import tri_feed_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    tri_feed_arbiter_if.slave  bus
);

    state_e               state_q, state_d;
    logic [BUNDLE_W-1:0]  bundle_q, bundle_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [1:0]           done_q, done_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [1:0]           win_s;
    logic [1:0]           gnt_s;
    logic                 nt_s;
    logic [COORD_W-1:0]   xo_s;
    logic [COORD_W-1:0]   yo_s;

    rr_arb2 u_rr_arb2 (
        .req0_i (bus.req0_i),
        .req1_i (bus.req1_i),
        .last_i (last_q),
        .win_o  (win_s)
    );

    // State and datapath registers; last-served starts at 1 so req0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bundle_q <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            done_q   <= 2'b00;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            bundle_q <= bundle_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE, done is a one-cycle pulse.
    always_comb begin
        state_d  = state_q;
        bundle_d = bundle_q;
        owner_d  = owner_q;
        last_d   = last_q;
        done_d   = 2'b00;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (!bus.busy_i && (bus.req0_i || bus.req1_i)) begin
                    state_d  = V1;
                    owner_d  = win_s[1];
                    bundle_d = win_s[1] ? bus.tri1_i : bus.tri0_i;
                end else begin
                    state_d  = IDLE;
                end
            end
            V1:      state_d = V2;
            V2:      state_d = V3;
            V3:      state_d = WAIT_HI;
            WAIT_HI: begin
                if (bus.busy_i) begin
                    state_d = WAIT_LO;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (!bus.busy_i) begin
                    state_d = IDLE;
                    done_d  = owner_q ? 2'b10 : 2'b01;
                    cnt_d   = cnt_q + 8'd1;
                    last_d  = owner_q;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state, owner and latched bundle registers.
    always_comb begin
        gnt_s = 2'b00;
        nt_s  = 1'b0;
        xo_s  = ZERO_PT;
        yo_s  = ZERO_PT;
        case (state_q)
            V1: begin
                gnt_s = owner_q ? 2'b10 : 2'b01;
                nt_s  = 1'b1;
                xo_s  = get_coord(bundle_q, IDX_X1);
                yo_s  = get_coord(bundle_q, IDX_Y1);
            end
            V2: begin
                xo_s = get_coord(bundle_q, IDX_X2);
                yo_s = get_coord(bundle_q, IDX_Y2);
            end
            V3: begin
                xo_s = get_coord(bundle_q, IDX_X3);
                yo_s = get_coord(bundle_q, IDX_Y3);
            end
            default: begin
                gnt_s = 2'b00;
                nt_s  = 1'b0;
            end
        endcase
    end

    assign bus.gnt0_o    = gnt_s[0];
    assign bus.gnt1_o    = gnt_s[1];
    assign bus.done0_o   = done_q[0];
    assign bus.done1_o   = done_q[1];
    assign bus.nt_o      = nt_s;
    assign bus.xo_o      = xo_s;
    assign bus.yo_o      = yo_s;
    assign bus.tri_cnt_o = cnt_q;

endmodule
